// File: rtl/aes_decrypt_iter_pkg.sv
// Shared types, tables and GF(2^8)/key-schedule helpers for the iterative
// AES-128 inverse cipher. Byte n of a block lives in bits [8n:8n+7];
// bytes 0-3 form column 0.
package aes_decrypt_iter_pkg;

  localparam int NR       = 10;
  localparam int KEY_BITS = 128;

  typedef logic [0:KEY_BITS-1] block_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } fsm_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant lookup; counter values outside 1..10 never reach the key path.
  function automatic logic [7:0] rcon_at(input logic [3:0] idx);
    if (idx >= 4'd1 && idx <= 4'd10) return RCON[idx];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [0:31] rot_word(input logic [0:31] w);
    return {w[8:31], w[0:7]};
  endfunction

  function automatic logic [0:31] sub_word(input logic [0:31] w);
    logic [0:31] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[w[8*i +: 8]];
    return r;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    return r;
  endfunction

  // Row r rotates right by r columns: out[r][c] = in[r][c-r].
  function automatic block_t inv_shift_rows(input block_t s);
    block_t r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[8*(4*c+row) +: 8] = s[8*(4*((c-row+4)%4)+row) +: 8];
    return r;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c)   +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      r[8*(4*c)   +: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
      r[8*(4*c+1) +: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
      r[8*(4*c+2) +: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
      r[8*(4*c+3) +: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
    end
    return r;
  endfunction

  // One forward key-schedule step: round key i-1 -> round key i.
  function automatic block_t fwd_step(input block_t k, input logic [7:0] rc);
    logic [0:31] n0, n1, n2, n3;
    n0 = k[0:31] ^ sub_word(rot_word(k[96:127])) ^ {rc, 24'h000000};
    n1 = k[32:63] ^ n0;
    n2 = k[64:95] ^ n1;
    n3 = k[96:127] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Inverse of fwd_step: round key i -> round key i-1, recovering w3 first.
  function automatic block_t rev_step(input block_t k, input logic [7:0] rc);
    logic [0:31] p0, p1, p2, p3;
    p3 = k[96:127] ^ k[64:95];
    p2 = k[64:95] ^ k[32:63];
    p1 = k[32:63] ^ k[0:31];
    p0 = k[0:31] ^ sub_word(rot_word(p3)) ^ {rc, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Ciphertext/key input and plaintext output handshake bundle.
// Signal names are from the decryptor's point of view.
interface aes_decrypt_iter_if;
  import aes_decrypt_iter_pkg::*;

  logic   i_valid;
  logic   o_ready;
  block_t i_cipher;
  block_t i_key;
  logic   o_valid;
  logic   i_ready;
  block_t o_plain;

  modport slave (
    input  i_valid, i_cipher, i_key, i_ready,
    output o_ready, o_valid, o_plain
  );

  modport master (
    output i_valid, i_cipher, i_key, i_ready,
    input  o_ready, o_valid, o_plain
  );
endinterface

// File: rtl/aes_decrypt_iter_inv_round.sv
// Combinational inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_decrypt_iter_inv_round
  import aes_decrypt_iter_pkg::*;
(
  input  block_t state,
  input  block_t round_key,
  input  logic   last,
  output block_t result
);

  block_t keyed;

  assign keyed  = inv_sub_bytes(inv_shift_rows(state)) ^ round_key;
  assign result = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one round per clock. The key schedule is
// first run forward to round key 10, then unwound one step per round.
module aes_decrypt_iter
  import aes_decrypt_iter_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset_n,
  aes_decrypt_iter_if.slave bus
);

  fsm_state_t fsm_q, fsm_d;
  block_t     data_q;
  block_t     key_q;
  block_t     plain_q;
  logic [3:0] ctr_q;
  logic       valid_q;
  logic       accept;
  block_t     round_out;

  assign bus.o_ready = (fsm_q == ST_IDLE);
  assign bus.o_valid = valid_q;
  assign bus.o_plain = plain_q;
  assign accept      = bus.i_valid && (fsm_q == ST_IDLE);

  aes_decrypt_iter_inv_round u_inv_round (
    .state     (data_q),
    .round_key (key_q),
    .last      (fsm_q == ST_FINAL),
    .result    (round_out)
  );

  // Control state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) fsm_q <= ST_IDLE;
    else            fsm_q <= fsm_d;
  end

  // Sequencing: key expansion, initial whitening, nine full rounds, last round, hold.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:   if (accept) fsm_d = ST_KEYEXP;
      ST_KEYEXP: if (ctr_q == 4'(NR)) fsm_d = ST_INIT;
      ST_INIT:   fsm_d = ST_ROUND;
      ST_ROUND:  if (ctr_q == 4'd1) fsm_d = ST_FINAL;
      ST_FINAL:  fsm_d = ST_DONE;
      ST_DONE:   if (bus.i_ready) fsm_d = ST_IDLE;
      default:   fsm_d = ST_IDLE;
    endcase
  end

  // Datapath: cipher state, rolling round key, round counter and output register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_q  <= '0;
      key_q   <= '0;
      plain_q <= '0;
      ctr_q   <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (accept) begin
            data_q <= bus.i_cipher;
            key_q  <= bus.i_key;
            ctr_q  <= 4'd1;
          end
        end
        ST_KEYEXP: begin
          key_q <= fwd_step(key_q, rcon_at(ctr_q));
          if (ctr_q != 4'(NR)) ctr_q <= ctr_q + 4'd1;
        end
        ST_INIT: begin
          data_q <= data_q ^ key_q;
          key_q  <= rev_step(key_q, rcon_at(ctr_q));
          ctr_q  <= 4'(NR - 1);
        end
        ST_ROUND: begin
          data_q <= round_out;
          key_q  <= rev_step(key_q, rcon_at(ctr_q));
          ctr_q  <= ctr_q - 4'd1;
        end
        ST_FINAL: begin
          plain_q <= round_out;
          valid_q <= 1'b1;
        end
        ST_DONE: begin
          if (bus.i_ready) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
